// File: rtl/mult_pkg.sv
// Shared defaults, product-width helper and parameter legality check for the
// mult_mac_pipe datapath.
package mult_pkg;

  localparam int A_W_DEF    = 36;
  localparam int B_W_DEF    = 36;
  localparam int STAGES_DEF = 3;
  localparam int ACC_W_DEF  = 80;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic bit params_ok(input int a_w, input int b_w,
                                   input int stages, input int acc_w);
    return (a_w >= 2) && (a_w <= 64) &&
           (b_w >= 2) && (b_w <= 64) &&
           (stages >= 2) && (stages <= 8) &&
           (acc_w >= prod_w(a_w, b_w));
  endfunction

endpackage

// File: rtl/mult_mac_pipe_if.sv
// Operand/result bundle of the multiply-accumulate pipe; the core uses the
// slave side, the producer/consumer the master side.
interface mult_mac_pipe_if
  import mult_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int ACC_W = ACC_W_DEF
);

  logic                          ce;
  logic                          valid_in;
  logic                          acc_en;
  logic                          acc_clr;
  logic signed [A_W-1:0]         data_a;
  logic signed [B_W-1:0]         data_b;
  logic                          valid_out;
  logic signed [A_W+B_W-1:0]     mult_result;
  logic signed [ACC_W-1:0]       acc_result;
  logic                          acc_ovf;

  modport master (
    output ce, valid_in, acc_en, acc_clr, data_a, data_b,
    input  valid_out, mult_result, acc_result, acc_ovf
  );

  modport slave (
    input  ce, valid_in, acc_en, acc_clr, data_a, data_b,
    output valid_out, mult_result, acc_result, acc_ovf
  );

endinterface

// File: rtl/pipe_delay.sv
// WIDTH x DEPTH shift register with clock enable; DEPTH=0 degenerates to a wire.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_regs
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (ce) begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/mult_mac_pipe.sv
// Pipelined full-precision signed multiplier with a tagged running accumulator
// and sticky signed-overflow flag; ce stalls every register in the pipe.
module mult_mac_pipe
  import mult_pkg::*;
#(
  parameter int A_W    = A_W_DEF,
  parameter int B_W    = B_W_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mult_mac_pipe_if.slave bus
);

  localparam int P_W = prod_w(A_W, B_W);

  if (!params_ok(A_W, B_W, STAGES, ACC_W)) begin : g_bad_params
    $fatal(1, "mult_mac_pipe: illegal A_W/B_W/STAGES/ACC_W combination");
  end

  logic                  s1_valid, s1_en, s1_clr;
  logic signed [A_W-1:0] s1_a;
  logic signed [B_W-1:0] s1_b;

  // Tags of a bubble are dropped here so later stages only need to look at valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_en    <= 1'b0;
      s1_clr   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (bus.ce) begin
      s1_valid <= bus.valid_in;
      s1_en    <= bus.valid_in & bus.acc_en;
      s1_clr   <= bus.valid_in & bus.acc_clr;
      s1_a     <= bus.data_a;
      s1_b     <= bus.data_b;
    end
  end

  logic signed [P_W-1:0] a_ext, b_ext, prod;
  assign a_ext = P_W'(s1_a);
  assign b_ext = P_W'(s1_b);
  assign prod  = a_ext * b_ext;

  logic [P_W+2:0]        dly_in, dly_out;
  logic                  d_valid, d_en, d_clr;
  logic signed [P_W-1:0] d_prod;

  assign dly_in = {s1_valid, s1_en, s1_clr, prod};

  pipe_delay #(
    .WIDTH (P_W + 3),
    .DEPTH (STAGES - 2)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .ce   (bus.ce),
    .din  (dly_in),
    .dout (dly_out)
  );

  assign d_valid = dly_out[P_W+2];
  assign d_en    = dly_out[P_W+1];
  assign d_clr   = dly_out[P_W];
  assign d_prod  = dly_out[P_W-1:0];

  logic                    valid_q, ovf_q, ovf_now;
  logic signed [P_W-1:0]   mult_q;
  logic signed [ACC_W-1:0] acc_q, acc_ext, acc_sum;

  assign acc_ext = ACC_W'(d_prod);
  assign acc_sum = acc_q + acc_ext;
  assign ovf_now = (acc_q[ACC_W-1] == acc_ext[ACC_W-1]) &&
                   (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      mult_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.ce) begin
      valid_q <= d_valid;
      if (d_valid) begin
        mult_q <= d_prod;
        if (d_clr) begin
          acc_q <= acc_ext;
          ovf_q <= 1'b0;
        end else if (d_en) begin
          acc_q <= acc_sum;
          ovf_q <= ovf_q | ovf_now;
        end
      end
    end
  end

  assign bus.valid_out   = valid_q;
  assign bus.mult_result = mult_q;
  assign bus.acc_result  = acc_q;
  assign bus.acc_ovf     = ovf_q;

endmodule
